// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and hazard controller for an RV32IM 5-stage pipeline with
// NUM_SRC source operands per instruction.
//
//  * Chooses the bypass source for each EX operand (EX/MEM beats MEM/WB).
//  * Detects load-use hazards between the load in EX and the consumer in ID.
//  * Tracks one in-flight multi-cycle M-extension op (DIV/DIVU/REM/REMU)
//    with a small scoreboard FSM (IDLE -> BUSY -> WB). The result is
//    written back through a dedicated regfile port, signalled by long_wb.
//  * Stalls ID on RAW/WAW hazards against the pending long-op destination
//    and on a second long op while the divider is occupied.
//
// Parameters
//   REG_AW   register address width
//   NUM_SRC  source operands per instruction
//   LONG_LAT long-op latency, issue cycle to writeback pulse (must be >= 2)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_ex_rs/_used    EX operand addresses (packed, REG_AW each) / read flags
//   if_id_rs/_used    ID operand addresses (same packing) / read flags
//   if_id_rd, if_id_reg_write, if_id_long   ID destination / writes rd / is long op
//   id_ex_rd, id_ex_mem_read                EX destination / EX is a load
//   ex_mem_rd, ex_mem_reg_write             MEM-stage destination / writes rd
//   mem_wb_rd, mem_wb_reg_write             WB-stage destination / writes rd
//   long_start, long_rd                     long op issues in EX / its destination
//   fwd_sel          per operand [2i+:2]: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_if_id      hold PC and IF/ID
//   flush_id_ex      insert bubble into ID/EX
//   long_busy        long-op FSM not idle
//   long_wb          one-cycle writeback pulse for the long op
//   long_wb_rd       destination for long_wb
//   long_overlap_err sticky: long_start seen while a long op was in flight
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LONG_LAT = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
    input  logic [NUM_SRC-1:0]        id_ex_rs_used,
    input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
    input  logic [NUM_SRC-1:0]        if_id_rs_used,
    input  logic [REG_AW-1:0]         if_id_rd,
    input  logic                      if_id_reg_write,
    input  logic                      if_id_long,
    input  logic [REG_AW-1:0]         id_ex_rd,
    input  logic                      id_ex_mem_read,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      ex_mem_reg_write,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      mem_wb_reg_write,
    input  logic                      long_start,
    input  logic [REG_AW-1:0]         long_rd,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall_if_id,
    output logic                      flush_id_ex,
    output logic                      long_busy,
    output logic                      long_wb,
    output logic [REG_AW-1:0]         long_wb_rd,
    output logic                      long_overlap_err
);

    localparam int CNT_W = $clog2(LONG_LAT);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } long_state_e;

    long_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_AW-1:0]  pend_rd_q, pend_rd_d;
    logic               err_q, err_d;

    logic               issue_now;
    logic               lu, sb, st;

    // -------------------------------------------------------------------------
    // Bypass selection
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default at the top so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_AW-1:0] rs;
            rs = id_ex_rs[i*REG_AW +: REG_AW];
            if (ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == rs && id_ex_rs_used[i])
                fwd_sel[2*i +: 2] = SEL_MEM;
            else if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == rs && id_ex_rs_used[i])
                fwd_sel[2*i +: 2] = SEL_WB;
            else
                fwd_sel[2*i +: 2] = SEL_RF;
        end
    end

    // -------------------------------------------------------------------------
    // Long-op scoreboard FSM
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_rd_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
            err_q     <= err_d;
        end
    end

    // A long op that issues while the divider is occupied is dropped; the
    // in-flight op keeps its destination and count, and the error flag sticks.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        err_d      = err_q;
        long_wb    = 1'b0;
        long_wb_rd = '0;

        if (long_start && state_q != S_IDLE)
            err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (long_start) begin
                    pend_rd_d = long_rd;
                    // BUSY runs LONG_LAT-1 cycles (cnt down to 0 inclusive),
                    // then WB, so the pulse lands LONG_LAT cycles after issue.
                    cnt_d     = CNT_W'(LONG_LAT - 2);
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0)
                    state_d = S_WB;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            S_WB: begin
                long_wb    = 1'b1;
                long_wb_rd = pend_rd_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign long_busy        = (state_q != S_IDLE);
    assign long_overlap_err = err_q;

    // An op issuing this cycle is not yet visible in the FSM, so it is
    // treated as occupying the divider with destination long_rd.
    assign issue_now = long_start && (state_q == S_IDLE);

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    always_comb begin
        logic [REG_AW-1:0] rs;
        logic              raw_pend, raw_issue;

        lu        = 1'b0;
        raw_pend  = 1'b0;
        raw_issue = 1'b0;
        rs        = '0;

        for (int i = 0; i < NUM_SRC; i++) begin
            rs = if_id_rs[i*REG_AW +: REG_AW];
            if (if_id_rs_used[i]) begin
                if (rs == id_ex_rd)  lu        = 1'b1;
                if (rs == pend_rd_q) raw_pend  = 1'b1;
                if (rs == long_rd)   raw_issue = 1'b1;
            end
        end
        lu = lu && id_ex_mem_read && (id_ex_rd != '0);

        // sb stays up through WB: the regfile write happens at the end of
        // that cycle, so the consumer may only leave ID on the next one.
        sb = (long_busy && pend_rd_q != '0 &&
              (raw_pend || (if_id_reg_write && if_id_rd == pend_rd_q)))
          || (issue_now && long_rd != '0 &&
              (raw_issue || (if_id_reg_write && if_id_rd == long_rd)));

        st = if_id_long && (long_busy || issue_now);
    end

    assign stall_if_id = lu | sb | st;
    assign flush_id_ex = lu | sb | st;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed bench for fwd_hazard_ctrl with LONG_LAT=4. Inputs change 1 ns after
// the rising edge and outputs are sampled 2 ns later, mid-cycle. Cycle numbers
// in comments count rising edges from the start of each scenario.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 2;
    localparam int LONG_LAT = 4;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] id_ex_rs;
    logic [NUM_SRC-1:0]        id_ex_rs_used;
    logic [NUM_SRC*REG_AW-1:0] if_id_rs;
    logic [NUM_SRC-1:0]        if_id_rs_used;
    logic [REG_AW-1:0]         if_id_rd;
    logic                      if_id_reg_write;
    logic                      if_id_long;
    logic [REG_AW-1:0]         id_ex_rd;
    logic                      id_ex_mem_read;
    logic [REG_AW-1:0]         ex_mem_rd;
    logic                      ex_mem_reg_write;
    logic [REG_AW-1:0]         mem_wb_rd;
    logic                      mem_wb_reg_write;
    logic                      long_start;
    logic [REG_AW-1:0]         long_rd;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall_if_id;
    logic                      flush_id_ex;
    logic                      long_busy;
    logic                      long_wb;
    logic [REG_AW-1:0]         long_wb_rd;
    logic                      long_overlap_err;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_ctrl #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .LONG_LAT(LONG_LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_ex_rs        (id_ex_rs),
        .id_ex_rs_used   (id_ex_rs_used),
        .if_id_rs        (if_id_rs),
        .if_id_rs_used   (if_id_rs_used),
        .if_id_rd        (if_id_rd),
        .if_id_reg_write (if_id_reg_write),
        .if_id_long      (if_id_long),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write),
        .long_start      (long_start),
        .long_rd         (long_rd),
        .fwd_sel         (fwd_sel),
        .stall_if_id     (stall_if_id),
        .flush_id_ex     (flush_id_ex),
        .long_busy       (long_busy),
        .long_wb         (long_wb),
        .long_wb_rd      (long_wb_rd),
        .long_overlap_err(long_overlap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_rs         = '0;
        id_ex_rs_used    = '0;
        if_id_rs         = '0;
        if_id_rs_used    = '0;
        if_id_rd         = '0;
        if_id_reg_write  = 1'b0;
        if_id_long       = 1'b0;
        id_ex_rd         = '0;
        id_ex_mem_read   = 1'b0;
        ex_mem_rd        = '0;
        ex_mem_reg_write = 1'b0;
        mem_wb_rd        = '0;
        mem_wb_reg_write = 1'b0;
        long_start       = 1'b0;
        long_rd          = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // ---------------- reset state ----------------
        #3;
        check("rst_busy",   long_busy, 0);
        check("rst_wb",     long_wb, 0);
        check("rst_wb_rd",  long_wb_rd, 0);
        check("rst_err",    long_overlap_err, 0);
        check("rst_stall",  stall_if_id, 0);
        // Forwarding stays live while reset is held.
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd3;
        id_ex_rs = {5'd0, 5'd3}; id_ex_rs_used = 2'b01;
        #1;
        check("rst_fwd_live", fwd_sel, 4'b0010);
        #3;
        rst_n = 1'b1;
        tick();

        // ---------------- forwarding ----------------
        clear_inputs();
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd5;
        mem_wb_reg_write = 1'b1; mem_wb_rd = 5'd5;
        id_ex_rs = {5'd5, 5'd5}; id_ex_rs_used = 2'b11;
        #2;
        check("fwd_both_mem", fwd_sel, 4'b1010);
        ex_mem_rd = 5'd6;
        #2;
        check("fwd_both_wb", fwd_sel, 4'b0101);

        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs = '0;
        #2;
        check("fwd_x0", fwd_sel, 4'b0000);

        ex_mem_rd = 5'd5; id_ex_rs = {5'd5, 5'd5}; id_ex_rs_used = 2'b01;
        #2;
        check("fwd_unused_op1", fwd_sel, 4'b0010);

        ex_mem_rd = 5'd4; mem_wb_rd = 5'd3;
        id_ex_rs = {5'd4, 5'd3}; id_ex_rs_used = 2'b11;
        #2;
        check("fwd_mixed", fwd_sel, 4'b1001);

        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
        #2;
        check("fwd_no_write", fwd_sel, 4'b0000);

        // ---------------- load-use ----------------
        tick();
        clear_inputs();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd7;
        if_id_rs = {5'd0, 5'd7}; if_id_rs_used = 2'b01;
        #2;
        check("lu_stall", stall_if_id, 1);
        check("lu_flush", flush_id_ex, 1);
        if_id_rs_used = 2'b10;
        #1;
        check("lu_unused_src", stall_if_id, 0);
        if_id_rs_used = 2'b01; id_ex_rd = 5'd0; if_id_rs = '0;
        #1;
        check("lu_x0", stall_if_id, 0);

        tick();
        // The load has moved to MEM, the consumer to EX.
        clear_inputs();
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd7;
        id_ex_rs = {5'd0, 5'd7}; id_ex_rs_used = 2'b01;
        #2;
        check("lu_next_stall", stall_if_id, 0);
        check("lu_next_fwd", fwd_sel, 4'b0010);

        // ---------------- long op, RAW on x9 ----------------
        tick();
        clear_inputs();
        long_start = 1'b1; long_rd = 5'd9;
        if_id_rs = {5'd0, 5'd9}; if_id_rs_used = 2'b01;
        #2;
        check("long_c0_stall", stall_if_id, 1);
        check("long_c0_busy", long_busy, 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            long_start = 1'b0;
            #2;
            check($sformatf("long_c%0d_busy", c), long_busy, 1);
            check($sformatf("long_c%0d_stall", c), stall_if_id, 1);
            check($sformatf("long_c%0d_wb", c), long_wb, (c == 4) ? 1 : 0);
            check($sformatf("long_c%0d_wb_rd", c), long_wb_rd, (c == 4) ? 9 : 0);
        end
        tick();
        #2;
        check("long_c5_busy", long_busy, 0);
        check("long_c5_stall", stall_if_id, 0);
        check("long_c5_wb", long_wb, 0);

        // ---------------- long op to x0, structural hazard ----------------
        tick();
        clear_inputs();
        long_start = 1'b1; long_rd = 5'd0;
        if_id_rs = {5'd0, 5'd0}; if_id_rs_used = 2'b01;
        #2;
        check("st_c0_rd0_nostall", stall_if_id, 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            long_start = 1'b0; if_id_long = 1'b1;
            #2;
            check($sformatf("st_c%0d_stall", c), stall_if_id, 1);
            if (c == 4) begin
                check("st_c4_wb", long_wb, 1);
                check("st_c4_wb_rd", long_wb_rd, 0);
            end
        end
        tick();
        #2;
        check("st_c5_stall", stall_if_id, 0);

        // ---------------- overlap, WAW, reset mid-BUSY ----------------
        tick();
        clear_inputs();
        long_start = 1'b1; long_rd = 5'd11;
        tick();                              // cycle 1
        long_start = 1'b0;
        if_id_reg_write = 1'b1; if_id_rd = 5'd11;
        #2;
        check("waw_stall", stall_if_id, 1);
        tick();                              // cycle 2: overlapping issue
        long_start = 1'b1; long_rd = 5'd12;
        if_id_rd = 5'd12;
        #2;
        check("ovl_c2_ignored_rd", stall_if_id, 0);
        check("ovl_c2_err", long_overlap_err, 0);
        tick();                              // cycle 3
        long_start = 1'b0; if_id_reg_write = 1'b0;
        if_id_rs = {5'd0, 5'd11}; if_id_rs_used = 2'b01;
        #2;
        check("ovl_c3_err", long_overlap_err, 1);
        check("ovl_c3_busy", long_busy, 1);
        check("ovl_c3_pend_kept", stall_if_id, 1);
        rst_n = 1'b0;
        #1;
        check("ovl_rst_busy", long_busy, 0);
        check("ovl_rst_err", long_overlap_err, 0);
        check("ovl_rst_stall", stall_if_id, 0);
        #2;
        rst_n = 1'b1;
        for (int c = 4; c <= 6; c++) begin
            tick();
            #2;
            check($sformatf("ovl_c%0d_no_wb", c), long_wb, 0);
        end
        check("ovl_err_clear", long_overlap_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
